// File: rtl/mod_arith_pkg.sv
// Shared constants and FSM state type for the modular add/subtract controller.
package mod_arith_pkg;

    localparam int unsigned MP_W = 1027;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE1 = 3'd1,
        ST_WAIT1  = 3'd2,
        ST_ISSUE2 = 3'd3,
        ST_WAIT2  = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Computes (A +/- B) mod M using one or two operations on an external mp adder.
// MOD_ADDSUB_TIMEOUT_EN adds a per-operation watchdog and a sticky err output.
module mod_addsub_ctrl
    import mod_arith_pkg::*;
#(
    parameter int unsigned W = MP_W
`ifdef MOD_ADDSUB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         subtract,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_m,
    output logic [W-1:0] result,
    output logic         done,
    output logic         add_start,
    output logic         add_subtract,
    output logic [W-1:0] add_in_a,
    output logic [W-1:0] add_in_b,
    input  logic [W:0]   add_result,
    input  logic         add_done
`ifdef MOD_ADDSUB_TIMEOUT_EN
    , output logic       err
`endif
);

    state_e       state_q, state_d;
    logic [W-1:0] m_q, m_d;
    logic         sub_q, sub_d;
    logic [W-1:0] r_q, r_d;
    logic [W-1:0] result_q, result_d;
    logic         done_q, done_d;
    logic         add_start_q, add_start_d;
    logic         add_subtract_q, add_subtract_d;
    logic [W-1:0] add_in_a_q, add_in_a_d;
    logic [W-1:0] add_in_b_q, add_in_b_d;
`ifdef MOD_ADDSUB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d        = state_q;
        m_d            = m_q;
        sub_d          = sub_q;
        r_d            = r_q;
        result_d       = result_q;
        done_d         = 1'b0;
        add_start_d    = 1'b0;
        add_subtract_d = add_subtract_q;
        add_in_a_d     = add_in_a_q;
        add_in_b_d     = add_in_b_q;
`ifdef MOD_ADDSUB_TIMEOUT_EN
        cnt_d          = cnt_q;
        err_d          = err_q;
`endif
        unique case (state_q)
            // Adder handshake outputs are set one cycle early so they are registered in ISSUE.
            ST_IDLE: if (start) begin
                m_d            = in_m;
                sub_d          = subtract;
                add_in_a_d     = in_a;
                add_in_b_d     = in_b;
                add_subtract_d = subtract;
                add_start_d    = 1'b1;
                state_d        = ST_ISSUE1;
            end
            ST_ISSUE1: state_d = ST_WAIT1;
            ST_WAIT1: if (add_done) begin
                r_d = add_result[W-1:0];
                if (!sub_q || add_result[W]) begin
                    add_in_a_d     = add_result[W-1:0];
                    add_in_b_d     = m_q;
                    add_subtract_d = !sub_q;
                    add_start_d    = 1'b1;
                    state_d        = ST_ISSUE2;
                end else begin
                    result_d = add_result[W-1:0];
                    done_d   = 1'b1;
                    state_d  = ST_FIN;
                end
            end
            ST_ISSUE2: state_d = ST_WAIT2;
            // Add: a borrow on R-M means R was already reduced.
            ST_WAIT2: if (add_done) begin
                result_d = (!sub_q && add_result[W]) ? r_q : add_result[W-1:0];
                done_d   = 1'b1;
                state_d  = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef MOD_ADDSUB_TIMEOUT_EN
        // Counter holds cycles elapsed since add_start, so err rises exactly TIMEOUT cycles later.
        if (state_q == ST_IDLE && start) begin
            err_d = 1'b0;
        end else if (state_q == ST_ISSUE1 || state_q == ST_ISSUE2) begin
            cnt_d = CW'(1);
        end else if ((state_q == ST_WAIT1 || state_q == ST_WAIT2) && !add_done) begin
            if (cnt_q >= CW'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            m_q            <= '0;
            sub_q          <= 1'b0;
            r_q            <= '0;
            result_q       <= '0;
            done_q         <= 1'b0;
            add_start_q    <= 1'b0;
            add_subtract_q <= 1'b0;
            add_in_a_q     <= '0;
            add_in_b_q     <= '0;
`ifdef MOD_ADDSUB_TIMEOUT_EN
            cnt_q          <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            m_q            <= m_d;
            sub_q          <= sub_d;
            r_q            <= r_d;
            result_q       <= result_d;
            done_q         <= done_d;
            add_start_q    <= add_start_d;
            add_subtract_q <= add_subtract_d;
            add_in_a_q     <= add_in_a_d;
            add_in_b_q     <= add_in_b_d;
`ifdef MOD_ADDSUB_TIMEOUT_EN
            cnt_q          <= cnt_d;
            err_q          <= err_d;
`endif
        end
    end

    assign result       = result_q;
    assign done         = done_q;
    assign add_start    = add_start_q;
    assign add_subtract = add_subtract_q;
    assign add_in_a     = add_in_a_q;
    assign add_in_b     = add_in_b_q;
`ifdef MOD_ADDSUB_TIMEOUT_EN
    assign err          = err_q;
`endif

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Self-checking bench for mod_addsub_ctrl with a behavioural mp adder (1..5 cycle done delay).
// Build with MOD_ADDSUB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_mod_addsub_ctrl;
    import mod_arith_pkg::*;

    localparam int unsigned W  = MP_W;
    localparam int          TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
    logic [W-1:0] result, add_in_a, add_in_b;
    logic         done, add_start, add_subtract;
    logic [W:0]   add_result = '0;
    logic         add_done;
    logic         model_done = 1'b0, stray_done = 1'b0;
`ifdef MOD_ADDSUB_TIMEOUT_EN
    logic         err;
`endif

    assign add_done = model_done | stray_done;

    mod_addsub_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .result(result), .done(done),
        .add_start(add_start), .add_subtract(add_subtract),
        .add_in_a(add_in_a), .add_in_b(add_in_b),
        .add_result(add_result), .add_done(add_done)
`ifdef MOD_ADDSUB_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural adder: captures operands on add_start, answers after model_delay cycles.
    logic         pending = 1'b0;
    int           dly = 0;
    logic [W:0]   res_hold = '0;
    int           model_delay = 1;
    bit           model_mute = 1'b0;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (pending) begin
            if (dly <= 1) begin
                model_done <= 1'b1;
                add_result <= res_hold;
                pending    <= 1'b0;
            end else begin
                dly <= dly - 1;
            end
        end
        if (add_start && !model_mute) begin
            pending  <= 1'b1;
            dly      <= model_delay;
            res_hold <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                     : ({1'b0, add_in_a} + {1'b0, add_in_b});
        end
    end

    int   start_cnt = 0, done_cnt = 0;
    logic mode_log[$];
    always @(negedge clk) begin
        if (add_start) begin
            start_cnt++;
            mode_log.push_back(add_subtract);
        end
        if (done) done_cnt++;
    end

    int           checks = 0, failures = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] model_res(input logic s, input logic [W-1:0] a, b, m);
        logic [W:0] t;
        if (!s) begin
            t = {1'b0, a} + {1'b0, b};
            if (t >= {1'b0, m}) t = t - {1'b0, m};
        end else if (a >= b) begin
            t = {1'b0, a} - {1'b0, b};
        end else begin
            t = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < 33; i++) v = {v[W-33:0], $urandom()};
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_start(input logic s, input logic [W-1:0] a, b, m);
        start = 1'b1; subtract = s; in_a = a; in_b = b; in_m = m;
    endtask

    task automatic wait_done(output bit seen, output logic [W-1:0] got);
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                seen = 1'b1;
                got  = result;
                break;
            end
            tick();
        end
    endtask

    task automatic score(input string name, input bit seen, input logic [W-1:0] got);
        logic [W-1:0] exp;
        exp = exp_q.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done: no done pulse within cycle budget", name);
        end else if (got !== exp) begin
            failures++;
            $display("FAIL %s_result: got(low128)=%h exp(low128)=%h", name, got[127:0], exp[127:0]);
        end
    endtask

    task automatic run_op(input string name, input logic s, input logic [W-1:0] a, b, m, input int d);
        logic [W-1:0] got;
        bit           seen;
        int           dc0, sc0, ml0, exp_st;
        exp_q.push_back(model_res(s, a, b, m));
        exp_st = (!s || a < b) ? 2 : 1;
        model_delay = d;
        dc0 = done_cnt; sc0 = start_cnt; ml0 = mode_log.size();
        drive_start(s, a, b, m);
        tick();
        start = 1'b0;
        wait_done(seen, got);
        score(name, seen, got);
        tick(); tick();
        checks++;
        if (done_cnt - dc0 != 1) begin
            failures++;
            $display("FAIL %s_done_count: got %0d exp 1", name, done_cnt - dc0);
        end
        checks++;
        if (start_cnt - sc0 != exp_st) begin
            failures++;
            $display("FAIL %s_add_starts: got %0d exp %0d", name, start_cnt - sc0, exp_st);
        end else begin
            checks++;
            if (mode_log[ml0] !== s || (exp_st == 2 && mode_log[ml0+1] !== !s)) begin
                failures++;
                $display("FAIL %s_add_modes: got %b%b exp %b%b", name, mode_log[ml0],
                         (exp_st == 2) ? mode_log[ml0+1] : 1'b0, s, (exp_st == 2) ? !s : 1'b0);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (result !== '0) begin
            failures++; $display("FAIL reset_result: got %h exp 0", result[63:0]);
        end
        checks++;
        if ({done, add_start, add_subtract} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl: got %b exp 000", {done, add_start, add_subtract});
        end
        checks++;
        if ({add_in_a, add_in_b} !== '0) begin
            failures++; $display("FAIL reset_operands: got nonzero (a=%h b=%h) exp 0", add_in_a[63:0], add_in_b[63:0]);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_spec_vectors();
        run_op("add_5_7",  1'b0, W'(5), W'(7), W'(11), 1);
        run_op("add_3_4",  1'b0, W'(3), W'(4), W'(11), 3);
        run_op("sub_3_5",  1'b1, W'(3), W'(5), W'(11), 5);
        run_op("sub_9_4",  1'b1, W'(9), W'(4), W'(11), 2);
    endtask

    task automatic test_boundaries();
        logic [W-1:0] mmax;
        mmax = '1;
        mmax = mmax >> 1;
        run_op("add_zero",     1'b0, W'(0), W'(0), W'(11), 1);
        run_op("add_eq_m",     1'b0, W'(10), W'(1), W'(11), 2);
        run_op("sub_equal",    1'b1, W'(7), W'(7), W'(11), 4);
        run_op("add_max",      1'b0, mmax - 1, mmax - 1, mmax, 5);
        run_op("sub_0_max",    1'b1, W'(0), mmax - 1, mmax, 3);
    endtask

    task automatic test_random();
        logic [W-1:0] m, a, b;
        for (int i = 0; i < 8; i++) begin
            m = (rand_w() >> 2) | W'(1);
            a = rand_w() % m;
            b = rand_w() % m;
            run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), a, b, m, int'($urandom_range(1, 5)));
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] got;
        bit           seen;
        int           dc0, sc0;
        exp_q.push_back(model_res(1'b0, W'(5), W'(7), W'(11)));
        model_delay = 5;
        dc0 = done_cnt; sc0 = start_cnt;
        drive_start(1'b0, W'(5), W'(7), W'(11));
        tick();
        start = 1'b0;
        tick();
        drive_start(1'b1, W'(9), W'(4), W'(11));
        tick();
        start = 1'b0;
        wait_done(seen, got);
        score("ignore_start", seen, got);
        repeat (20) tick();
        checks++;
        if (done_cnt - dc0 != 1 || start_cnt - sc0 != 2) begin
            failures++;
            $display("FAIL ignore_start_counts: done=%0d starts=%0d exp done=1 starts=2", done_cnt - dc0, start_cnt - sc0);
        end
    endtask

    task automatic test_stray_done();
        int dc0, sc0;
        dc0 = done_cnt; sc0 = start_cnt;
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        repeat (4) tick();
        checks++;
        if (done_cnt != dc0 || start_cnt != sc0) begin
            failures++;
            $display("FAIL stray_done_idle: done=%0d starts=%0d exp 0 0", done_cnt - dc0, start_cnt - sc0);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got;
        bit           seen;
        int           dc0;
        dc0 = done_cnt;
        exp_q.push_back(model_res(1'b0, W'(8), W'(9), W'(13)));
        model_delay = 2;
        drive_start(1'b0, W'(8), W'(9), W'(13));
        tick();
        start = 1'b0;
        wait_done(seen, got);
        score("b2b_first", seen, got);
        drive_start(1'b1, W'(1), W'(2), W'(13));
        tick();
        exp_q.push_back(model_res(1'b1, W'(12), W'(3), W'(13)));
        drive_start(1'b1, W'(12), W'(3), W'(13));
        tick();
        start = 1'b0;
        wait_done(seen, got);
        score("b2b_second", seen, got);
        repeat (10) tick();
        checks++;
        if (done_cnt - dc0 != 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d exp 2", done_cnt - dc0);
        end
    endtask

    task automatic test_rst_mid();
        int dc0, sc0;
        dc0 = done_cnt; sc0 = start_cnt;
        exp_q.push_back(model_res(1'b0, W'(5), W'(7), W'(11)));
        model_delay = 5;
        drive_start(1'b0, W'(5), W'(7), W'(11));
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && start_cnt - sc0 < 2; i++) tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({result, done, add_start, add_subtract, add_in_a, add_in_b} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got result=%h ctrl=%b a=%h b=%h exp all 0", result[63:0],
                     {done, add_start, add_subtract}, add_in_a[63:0], add_in_b[63:0]);
        end
        tick();
        rst = 1'b0;
        void'(exp_q.pop_back());
        repeat (12) tick();
        checks++;
        if (done_cnt != dc0 || start_cnt - sc0 != 2) begin
            failures++;
            $display("FAIL rst_mid_quiet: done=%0d starts=%0d exp done=0 starts=2", done_cnt - dc0, start_cnt - sc0);
        end
        run_op("after_rst", 1'b1, W'(2), W'(6), W'(11), 1);
    endtask

`ifdef MOD_ADDSUB_TIMEOUT_EN
    task automatic test_timeout();
        int dc0, k;
        dc0 = done_cnt;
        model_mute = 1'b1;
        drive_start(1'b0, W'(1), W'(2), W'(11));
        tick();
        start = 1'b0;
        k = 0;
        for (int i = 0; i < 60 && err !== 1'b1; i++) begin
            tick();
            k++;
        end
        checks++;
        if (k != TO) begin
            failures++;
            $display("FAIL timeout_latency: err after %0d cycles exp %0d", k, TO);
        end
        repeat (3) tick();
        checks++;
        if (err !== 1'b1 || done_cnt != dc0) begin
            failures++;
            $display("FAIL timeout_sticky: err=%b done=%0d exp err=1 done=0", err, done_cnt - dc0);
        end
        model_mute = 1'b0;
        run_op("post_timeout", 1'b0, W'(4), W'(5), W'(11), 1);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: err=%b exp 0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_spec_vectors();
        test_boundaries();
        test_random();
        test_ignore_start();
        test_stray_done();
        test_back_to_back();
        test_rst_mid();
`ifdef MOD_ADDSUB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
